// File: rtl/axi_read_arbiter_if.sv
// rtl/axi_read_arbiter_if.sv - requester and read-channel signal bundle for axi_read_arbiter
// Purpose: groups the per-requester request/grant/done lines and the read-channel
//   start/target/done handshake shared by the arbiter and its environment.
// Modports:
//   master - the arbiter: samples req_valid/req_addr/req_len/rd_accepted/rd_done,
//            drives req_ready/req_done/rd_start/rd_addr/rd_len/rd_done_ack/busy/owner_id/timeout_err
//   slave  - requesters plus read channel: the opposite directions
interface axi_read_arbiter_if #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int READ_BURST_LEN = 8,
  parameter int ID_WIDTH       = 1
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr;
  logic [NUM_REQ*READ_BURST_LEN-1:0] req_len;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0]                req_done;
  logic                              rd_start;
  logic [ADDR_WIDTH-1:0]             rd_addr;
  logic [READ_BURST_LEN-1:0]         rd_len;
  logic                              rd_accepted;
  logic                              rd_done;
  logic                              rd_done_ack;
  logic                              busy;
  logic [ID_WIDTH-1:0]               owner_id;
  logic                              timeout_err;

  modport master (
    input  req_valid, req_addr, req_len, rd_accepted, rd_done,
    output req_ready, req_done, rd_start, rd_addr, rd_len, rd_done_ack,
           busy, owner_id, timeout_err
  );

  modport slave (
    output req_valid, req_addr, req_len, rd_accepted, rd_done,
    input  req_ready, req_done, rd_start, rd_addr, rd_len, rd_done_ack,
           busy, owner_id, timeout_err
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - round-robin sequencer sharing one AXI read channel among requesters
// Purpose: accepts one burst request (addr, len) at a time from NUM_REQ requesters,
//   issues it to the read channel, waits for the channel's done, acknowledges it and
//   pulses req_done to the owning requester. Read data does not pass through here.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   bus  - axi_read_arbiter_if.master: req_valid/req_addr/req_len in, req_ready (comb grant
//          pulse) and req_done out; rd_start/rd_addr/rd_len/rd_done_ack out, rd_accepted/rd_done
//          in; busy, owner_id and sticky watchdog timeout_err out
module axi_read_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int READ_BURST_LEN = 8,
  parameter int ID_WIDTH       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                rst,
  axi_read_arbiter_if.master bus
);
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK} state_t;

  state_t                    state;
  logic [ID_WIDTH-1:0]       rr_ptr;
  logic [CNT_W-1:0]          wd_cnt;

  logic                      grant_found;
  logic [ID_WIDTH-1:0]       grant_idx;
  logic [ID_WIDTH-1:0]       grant_next;
  logic [ADDR_WIDTH-1:0]     grant_addr;
  logic [READ_BURST_LEN-1:0] grant_len;

  // Round-robin pick: the lowest valid index at or above rr_ptr wins; if none, the
  // lowest valid index overall (the wrap-around part of the scan).
  always_comb begin
    int  hi_idx;
    int  any_idx;
    int  sel;
    logic hi_found;
    hi_idx      = 0;
    any_idx     = 0;
    sel         = 0;
    hi_found    = 1'b0;
    grant_found = 1'b0;
    grant_addr  = '0;
    grant_len   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus.req_valid[j]) begin
        any_idx     = j;
        grant_found = 1'b1;
        if (j >= int'(rr_ptr)) begin
          hi_idx   = j;
          hi_found = 1'b1;
        end
      end
    end
    sel = hi_found ? hi_idx : any_idx;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (j == sel) begin
        grant_addr = bus.req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        grant_len  = bus.req_len[j*READ_BURST_LEN +: READ_BURST_LEN];
      end
    end
    grant_idx  = ID_WIDTH'(sel);
    grant_next = (sel == NUM_REQ - 1) ? '0 : ID_WIDTH'(sel + 1);
  end

  // The grant is combinational so the requester sees acceptance in the same cycle
  // its request is latched; held off during reset so all outputs read 0.
  assign bus.req_ready = (state == IDLE && grant_found && !rst) ?
                         (NUM_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      wd_cnt          <= '0;
      bus.req_done    <= '0;
      bus.rd_start    <= 1'b0;
      bus.rd_addr     <= '0;
      bus.rd_len      <= '0;
      bus.rd_done_ack <= 1'b0;
      bus.busy        <= 1'b0;
      bus.owner_id    <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            bus.rd_addr  <= grant_addr;
            bus.rd_len   <= grant_len;
            bus.owner_id <= grant_idx;
            rr_ptr       <= grant_next;
            bus.rd_start <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // rd_done here is a channel protocol error and is deliberately ignored.
          wd_cnt <= '0;
          if (bus.rd_accepted) begin
            bus.rd_start <= 1'b0;
            state        <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.rd_done) begin
            bus.rd_done_ack <= 1'b1;
            bus.req_done    <= NUM_REQ'(1) << bus.owner_id;
            state           <= ACK;
          end else if (wd_cnt != CNT_MAX) begin
            // A started AXI burst cannot be aborted, so the watchdog only flags
            // and saturates; it never forces the FSM out of WAIT_DONE.
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == CNT_MAX - 1'b1) bus.timeout_err <= 1'b1;
          end
        end
        ACK: begin
          bus.rd_done_ack <= 1'b0;
          bus.req_done    <= '0;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
